// File: rtl/zc_pkg.sv
// Shared definitions for the zero-crossing phase capture block: FSM encoding,
// default comparator constants and the phase width used by the phase-lock controller.
package zc_pkg;

  localparam int PHASE_W     = 16;
  localparam int ADC_MID_DEF = 2048;
  localparam int HYST_DEF    = 64;

  typedef enum logic [1:0] {
    WAIT_LOW  = 2'd0,
    WAIT_HIGH = 2'd1,
    HOLDOFF   = 2'd2
  } zc_state_e;

  function automatic logic [PHASE_W-1:0] phase_add(input logic [PHASE_W-1:0] a,
                                                   input logic [PHASE_W-1:0] b);
    return a + b;
  endfunction

endpackage

// File: rtl/zc_hyst_cmp.sv
// Offset removal and strict hysteresis compare of one offset-binary ADC sample.
module zc_hyst_cmp
  import zc_pkg::*;
#(
  parameter int               ADC_W   = 12,
  parameter logic [ADC_W-1:0] ADC_MID = ADC_W'(ADC_MID_DEF),
  parameter logic [ADC_W-1:0] HYST    = ADC_W'(HYST_DEF)
) (
  input  logic [ADC_W-1:0] adc_data,
  output logic             is_low,
  output logic             is_high
);

  logic signed [ADC_W:0] sample_s;
  logic signed [ADC_W:0] hyst_s;

  // Samples sitting exactly on +/-HYST deliberately qualify as neither.
  always_comb begin
    sample_s = $signed({1'b0, adc_data}) - $signed({1'b0, ADC_MID});
    hyst_s   = $signed({1'b0, HYST});
    is_low   = (sample_s < -hyst_s);
    is_high  = (sample_s > hyst_s);
  end

endmodule

// File: rtl/zc_phase_capture.sv
// Rising zero-crossing detector that latches the offset-corrected DDS phase and flags loss of signal.
// Optional macro ZC_PERIOD_CAPTURE_EN adds the zc_period output (clocks between accepted crossings).
module zc_phase_capture
  import zc_pkg::*;
#(
  parameter int               ADC_W        = 12,
  parameter logic [ADC_W-1:0] ADC_MID      = ADC_W'(ADC_MID_DEF),
  parameter logic [ADC_W-1:0] HYST         = ADC_W'(HYST_DEF),
  parameter logic [15:0]      HOLDOFF_CLKS = 16'd600,
  parameter logic [23:0]      TIMEOUT_CLKS = 24'd6000000,
  parameter logic [15:0]      PHASE_OFFSET = 16'd0
) (
  input  logic               clk_60m,
  input  logic               rst,
  input  logic               adc_valid,
  input  logic [ADC_W-1:0]   adc_data,
  input  logic [PHASE_W-1:0] dds_phase16,
  output logic               phase_strobe,
  output logic [PHASE_W-1:0] phase_at_zc16,
`ifdef ZC_PERIOD_CAPTURE_EN
  output logic [23:0]        zc_period,
`endif
  output logic               sig_lost
);

  zc_state_e          state_q, state_d;
  logic [15:0]        hold_cnt_q, hold_cnt_d;
  logic [23:0]        tmo_cnt_q, tmo_cnt_d;
  logic               sig_lost_q, sig_lost_d;
  logic               strobe_q, strobe_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic               accept_s;
  logic               is_low_s;
  logic               is_high_s;
  logic               hold_done_s;

  zc_hyst_cmp #(
    .ADC_W   (ADC_W),
    .ADC_MID (ADC_MID),
    .HYST    (HYST)
  ) u_cmp (
    .adc_data (adc_data),
    .is_low   (is_low_s),
    .is_high  (is_high_s)
  );

  assign hold_done_s = (({1'b0, hold_cnt_q} + 17'd1) >= {1'b0, HOLDOFF_CLKS});

  // Crossing FSM: arm on a low sample, accept on a high one, then sit out the holdoff.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    accept_s   = 1'b0;
    case (state_q)
      WAIT_LOW: begin
        if (adc_valid && is_low_s) begin
          state_d = WAIT_HIGH;
        end else begin
          state_d = WAIT_LOW;
        end
      end
      WAIT_HIGH: begin
        if (adc_valid && is_high_s) begin
          accept_s   = 1'b1;
          state_d    = HOLDOFF;
          hold_cnt_d = 16'd0;
        end else begin
          state_d = WAIT_HIGH;
        end
      end
      HOLDOFF: begin
        if (hold_done_s) begin
          state_d    = WAIT_LOW;
          hold_cnt_d = 16'd0;
        end else begin
          hold_cnt_d = hold_cnt_q + 16'd1;
        end
      end
      default: begin
        state_d    = WAIT_LOW;
        hold_cnt_d = 16'd0;
      end
    endcase
  end

  // Capture, strobe and saturating loss-of-signal timer.
  always_comb begin
    strobe_d   = accept_s;
    phase_d    = phase_q;
    tmo_cnt_d  = tmo_cnt_q;
    sig_lost_d = sig_lost_q;
    if (accept_s) begin
      phase_d    = phase_add(dds_phase16, PHASE_OFFSET);
      tmo_cnt_d  = 24'd0;
      sig_lost_d = 1'b0;
    end else begin
      if (tmo_cnt_q >= TIMEOUT_CLKS) begin
        tmo_cnt_d = TIMEOUT_CLKS;
      end else begin
        tmo_cnt_d = tmo_cnt_q + 24'd1;
      end
      if (tmo_cnt_d >= TIMEOUT_CLKS) begin
        sig_lost_d = 1'b1;
      end else begin
        sig_lost_d = sig_lost_q;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk_60m) begin
    if (rst) begin
      state_q    <= WAIT_LOW;
      hold_cnt_q <= 16'd0;
      tmo_cnt_q  <= 24'd0;
      sig_lost_q <= 1'b1;
      strobe_q   <= 1'b0;
      phase_q    <= '0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
      sig_lost_q <= sig_lost_d;
      strobe_q   <= strobe_d;
      phase_q    <= phase_d;
    end
  end

  assign phase_strobe  = strobe_q;
  assign phase_at_zc16 = phase_q;
  assign sig_lost      = sig_lost_q;

`ifdef ZC_PERIOD_CAPTURE_EN
  logic [23:0] iv_cnt_q, iv_cnt_d;
  logic [23:0] iv_inc_s;
  logic [23:0] period_q, period_d;

  // Free-running interval counter; the incremented value is what a crossing reports.
  always_comb begin
    if (iv_cnt_q == 24'hFFFFFF) begin
      iv_inc_s = iv_cnt_q;
    end else begin
      iv_inc_s = iv_cnt_q + 24'd1;
    end
    iv_cnt_d = iv_inc_s;
    period_d = period_q;
    if (accept_s) begin
      iv_cnt_d = 24'd0;
      period_d = iv_inc_s;
    end else begin
      period_d = period_q;
    end
  end

  // Interval registers.
  always_ff @(posedge clk_60m) begin
    if (rst) begin
      iv_cnt_q <= 24'd0;
      period_q <= 24'd0;
    end else begin
      iv_cnt_q <= iv_cnt_d;
      period_q <= period_d;
    end
  end

  assign zc_period = period_q;
`endif

endmodule

// File: tb/tb_zc_phase_capture.sv
// Directed self-checking bench for zc_phase_capture (HOLDOFF 600, TIMEOUT 1000, OFFSET 100).
module tb_zc_phase_capture;

  logic        clk_60m;
  logic        rst;
  logic        adc_valid;
  logic [11:0] adc_data;
  logic [15:0] dds_phase16;
  logic        phase_strobe;
  logic [15:0] phase_at_zc16;
  logic        sig_lost;
`ifdef ZC_PERIOD_CAPTURE_EN
  logic [23:0] zc_period;
`endif

  int checks;
  int errors;
  int strobe_cnt;

  zc_phase_capture #(
    .ADC_W        (12),
    .HOLDOFF_CLKS (16'd600),
    .TIMEOUT_CLKS (24'd1000),
    .PHASE_OFFSET (16'd100)
  ) dut (
    .clk_60m       (clk_60m),
    .rst           (rst),
    .adc_valid     (adc_valid),
    .adc_data      (adc_data),
    .dds_phase16   (dds_phase16),
    .phase_strobe  (phase_strobe),
    .phase_at_zc16 (phase_at_zc16),
`ifdef ZC_PERIOD_CAPTURE_EN
    .zc_period     (zc_period),
`endif
    .sig_lost      (sig_lost)
  );

  initial clk_60m = 1'b0;
  always #5 clk_60m = ~clk_60m;

  always @(negedge clk_60m) begin
    if (phase_strobe === 1'b1) strobe_cnt++;
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk_60m);
      #1;
    end
  endtask

  task automatic send(input logic [11:0] d, input logic [15:0] p);
    adc_valid   = 1'b1;
    adc_data    = d;
    dds_phase16 = p;
    @(posedge clk_60m);
    #1;
    adc_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    idle(3);
    checks++; if (phase_strobe !== 1'b0) begin errors++; $display("FAIL reset_strobe got %b want 0", phase_strobe); end
    checks++; if (phase_at_zc16 !== 16'd0) begin errors++; $display("FAIL reset_phase got %0d want 0", phase_at_zc16); end
    checks++; if (sig_lost !== 1'b1) begin errors++; $display("FAIL reset_sig_lost got %b want 1", sig_lost); end
`ifdef ZC_PERIOD_CAPTURE_EN
    checks++; if (zc_period !== 24'd0) begin errors++; $display("FAIL reset_period got %0d want 0", zc_period); end
`endif
    rst = 1'b0;
    idle(2);
    send(12'd2200, 16'd0);
    idle(9);
    checks++; if (strobe_cnt !== 0) begin errors++; $display("FAIL high_without_low got %0d strobes want 0", strobe_cnt); end
  endtask

  task automatic test_capture;
    send(12'd1900, 16'd0);
    idle(9);
    send(12'd2200, 16'd12345);
    checks++; if (phase_strobe !== 1'b1) begin errors++; $display("FAIL capture_strobe got %b want 1", phase_strobe); end
    checks++; if (phase_at_zc16 !== 16'd12445) begin errors++; $display("FAIL capture_phase got %0d want 12445", phase_at_zc16); end
    checks++; if (sig_lost !== 1'b0) begin errors++; $display("FAIL capture_sig_lost got %b want 0", sig_lost); end
    idle(1);
    checks++; if (phase_strobe !== 1'b0) begin errors++; $display("FAIL strobe_width got %b want 0", phase_strobe); end
    checks++; if (phase_at_zc16 !== 16'd12445) begin errors++; $display("FAIL phase_hold got %0d want 12445", phase_at_zc16); end
    idle(610);
  endtask

  task automatic test_wrap;
    send(12'd1900, 16'd0);
    idle(9);
    send(12'd2200, 16'd65500);
    checks++; if (phase_strobe !== 1'b1) begin errors++; $display("FAIL wrap_strobe got %b want 1", phase_strobe); end
    checks++; if (phase_at_zc16 !== 16'd64) begin errors++; $display("FAIL wrap_phase got %0d want 64", phase_at_zc16); end
    idle(610);
  endtask

  task automatic test_hysteresis;
    int base;
    base = strobe_cnt;
    for (int i = 0; i < 3; i++) begin
      send(12'd1984, 16'd0);
      idle(9);
      send(12'd2112, 16'd0);
      idle(9);
    end
    checks++; if (strobe_cnt !== base) begin errors++; $display("FAIL hyst_exact got %0d strobes want %0d", strobe_cnt, base); end
    send(12'd1983, 16'd0);
    idle(9);
    send(12'd2113, 16'd1000);
    checks++; if (phase_strobe !== 1'b1) begin errors++; $display("FAIL hyst_just_past_strobe got %b want 1", phase_strobe); end
    checks++; if (phase_at_zc16 !== 16'd1100) begin errors++; $display("FAIL hyst_phase got %0d want 1100", phase_at_zc16); end
    idle(20);
    checks++; if (strobe_cnt !== base + 1) begin errors++; $display("FAIL hyst_single got %0d strobes want %0d", strobe_cnt, base + 1); end
    idle(600);
  endtask

  task automatic test_holdoff;
    int base;
    send(12'd1900, 16'd0);
    idle(9);
    send(12'd2200, 16'd200);
    checks++; if (phase_strobe !== 1'b1) begin errors++; $display("FAIL holdoff_first got %b want 1", phase_strobe); end
    base = strobe_cnt + 1;
    idle(289);
    send(12'd1900, 16'd0);
    idle(9);
    send(12'd2200, 16'd250);
    idle(2);
    checks++; if (strobe_cnt !== base) begin errors++; $display("FAIL holdoff_300 got %0d strobes want %0d", strobe_cnt, base); end
    idle(387);
    send(12'd1900, 16'd0);
    idle(9);
    send(12'd2200, 16'd300);
    checks++; if (phase_strobe !== 1'b1) begin errors++; $display("FAIL holdoff_700 got %b want 1", phase_strobe); end
    checks++; if (phase_at_zc16 !== 16'd400) begin errors++; $display("FAIL holdoff_700_phase got %0d want 400", phase_at_zc16); end
    base = strobe_cnt + 1;
    idle(599);
    send(12'd1900, 16'd0);
    send(12'd2200, 16'd450);
    idle(2);
    checks++; if (strobe_cnt !== base) begin errors++; $display("FAIL holdoff_edge got %0d strobes want %0d", strobe_cnt, base); end
    send(12'd1900, 16'd0);
    send(12'd2200, 16'd500);
    checks++; if (phase_strobe !== 1'b1) begin errors++; $display("FAIL holdoff_after_edge got %b want 1", phase_strobe); end
    checks++; if (phase_at_zc16 !== 16'd600) begin errors++; $display("FAIL holdoff_after_edge_phase got %0d want 600", phase_at_zc16); end
  endtask

  task automatic test_timeout;
    idle(999);
    checks++; if (sig_lost !== 1'b0) begin errors++; $display("FAIL timeout_999 got %b want 0", sig_lost); end
    idle(1);
    checks++; if (sig_lost !== 1'b1) begin errors++; $display("FAIL timeout_1000 got %b want 1", sig_lost); end
    idle(50);
    send(12'd1900, 16'd0);
    idle(9);
    checks++; if (sig_lost !== 1'b1) begin errors++; $display("FAIL timeout_held got %b want 1", sig_lost); end
    send(12'd2200, 16'd7);
    checks++; if (sig_lost !== 1'b0) begin errors++; $display("FAIL timeout_clear got %b want 0", sig_lost); end
    checks++; if (phase_strobe !== 1'b1) begin errors++; $display("FAIL timeout_strobe got %b want 1", phase_strobe); end
    checks++; if (phase_at_zc16 !== 16'd107) begin errors++; $display("FAIL timeout_phase got %0d want 107", phase_at_zc16); end
    idle(610);
  endtask

  task automatic test_reset_mid;
    int base;
    send(12'd1900, 16'd0);
    idle(3);
    adc_valid   = 1'b1;
    adc_data    = 12'd2200;
    dds_phase16 = 16'd77;
    rst         = 1'b1;
    @(posedge clk_60m);
    #1;
    adc_valid = 1'b0;
    rst       = 1'b0;
    checks++; if (phase_strobe !== 1'b0) begin errors++; $display("FAIL midreset_strobe got %b want 0", phase_strobe); end
    checks++; if (phase_at_zc16 !== 16'd0) begin errors++; $display("FAIL midreset_phase got %0d want 0", phase_at_zc16); end
    checks++; if (sig_lost !== 1'b1) begin errors++; $display("FAIL midreset_sig_lost got %b want 1", sig_lost); end
    base = strobe_cnt;
    idle(2);
    send(12'd2200, 16'd0);
    idle(3);
    checks++; if (strobe_cnt !== base) begin errors++; $display("FAIL midreset_rearm got %0d strobes want %0d", strobe_cnt, base); end
    send(12'd1900, 16'd0);
    idle(9);
    send(12'd2200, 16'd900);
    checks++; if (phase_at_zc16 !== 16'd1000) begin errors++; $display("FAIL midreset_phase_after got %0d want 1000", phase_at_zc16); end
`ifdef ZC_PERIOD_CAPTURE_EN
    checks++; if (zc_period !== 24'd17) begin errors++; $display("FAIL period_since_reset got %0d want 17", zc_period); end
`endif
    idle(998);
    send(12'd1900, 16'd0);
    send(12'd2200, 16'd1);
    checks++; if (phase_strobe !== 1'b1) begin errors++; $display("FAIL period_strobe got %b want 1", phase_strobe); end
    checks++; if (phase_at_zc16 !== 16'd101) begin errors++; $display("FAIL period_phase got %0d want 101", phase_at_zc16); end
`ifdef ZC_PERIOD_CAPTURE_EN
    checks++; if (zc_period !== 24'd1000) begin errors++; $display("FAIL period_1000 got %0d want 1000", zc_period); end
`endif
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    strobe_cnt  = 0;
    rst         = 1'b1;
    adc_valid   = 1'b0;
    adc_data    = 12'd2048;
    dds_phase16 = 16'd0;
    test_reset();
    test_capture();
    test_wrap();
    test_hysteresis();
    test_holdoff();
    test_timeout();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
